// File: rtl/lii_tx_mux.sv
// LII transmit mux: arbitrates NIN kernel streams onto one tagged physical channel via a 2-entry FIFO.
// Optional packet lock is enabled by defining LII_TX_PKT_LOCK_EN; the default build is beat round-robin.
module lii_tx_mux #(
  parameter int unsigned      NIN     = 2,
  parameter int unsigned      DW      = 48,
  parameter int unsigned      PW      = 64,
  parameter logic [7:0]       SRC_ID  = 8'h00,
  parameter logic [NIN*8-1:0] DST_IDS = '0
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic [NIN*DW-1:0] s_tdata,
  input  logic [NIN-1:0]    s_tvalid,
  input  logic [NIN-1:0]    s_tlast,
  output logic [NIN-1:0]    s_tready,
  output logic [PW-1:0]     lii_out_p0_tdata,
  output logic              lii_out_p0_tvalid,
  input  logic              lii_out_p0_tready,
  output logic [7:0]        lii_out_p0_src,
  output logic [7:0]        lii_out_p0_dst
);

  localparam int unsigned LW = (NIN > 1) ? $clog2(NIN) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   last_q, last_d;
  logic [1:0]      count_q, count_d;
  logic            wr_q, rd_q;
  logic [PW-1:0]   data_q [2];
  logic [7:0]      dst_q  [2];

  logic [LW-1:0]   gnt;
  logic            gnt_vld;
  logic            space;
  logic            push;
  logic            pop;
  logic            gnt_last;
  logic [PW-1:0]   push_data;
  logic [7:0]      push_dst;
  int unsigned     idx;

  // Rotating priority search from last+1; a locked packet keeps its stream
  always_comb begin
    gnt     = last_q;
    gnt_vld = 1'b0;
    idx     = 0;
    if (state_q == LOCKED) begin
      gnt_vld = 1'b1;
    end else begin
      for (int unsigned k = NIN; k >= 1; k--) begin
        idx = int'(last_q) + k;
        if (idx >= NIN) idx = idx - NIN;
        if (s_tvalid[LW'(idx)]) begin
          gnt     = LW'(idx);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  // Space comes from the registered count only, so a same-cycle pop never frees a slot
  assign space = (count_q < 2'd2);

  always_comb begin
    for (int unsigned i = 0; i < NIN; i++) begin
      s_tready[i] = space && gnt_vld && (LW'(i) == gnt);
    end
  end

  assign push      = space && gnt_vld && s_tvalid[gnt];
  assign pop       = (count_q != 2'd0) && lii_out_p0_tready;
  assign push_data = PW'(s_tdata[gnt*DW +: DW]);
  assign push_dst  = DST_IDS[gnt*8 +: 8];
  assign gnt_last  = s_tlast[gnt];

  always_comb begin
    count_d = count_q;
    last_d  = last_q;
    state_d = state_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;
    if (push) begin
      last_d = gnt;
`ifdef LII_TX_PKT_LOCK_EN
      state_d = gnt_last ? IDLE : LOCKED;
`else
      state_d = IDLE;
`endif
    end
  end

`ifndef LII_TX_PKT_LOCK_EN
  logic unused_tlast;
  assign unused_tlast = gnt_last;
`endif

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q <= IDLE;
      last_q  <= LW'(NIN - 1);
      count_q <= 2'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        dst_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      count_q <= count_d;
      if (push) begin
        data_q[wr_q] <= push_data;
        dst_q[wr_q]  <= push_dst;
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
    end
  end

  // Head of FIFO drives the link; everything reads zero while empty
  assign lii_out_p0_tvalid = (count_q != 2'd0);
  assign lii_out_p0_tdata  = lii_out_p0_tvalid ? data_q[rd_q] : '0;
  assign lii_out_p0_dst    = lii_out_p0_tvalid ? dst_q[rd_q] : 8'h00;
  assign lii_out_p0_src    = lii_out_p0_tvalid ? SRC_ID : 8'h00;

endmodule

// File: tb/tb_lii_tx_mux.sv
// Directed bench for lii_tx_mux: reset, single stream, round-robin, backpressure, mid-packet reset.
// Packet-lock ordering is exercised when LII_TX_PKT_LOCK_EN is defined.
module tb_lii_tx_mux;

  localparam int unsigned NIN = 2;
  localparam int unsigned DW  = 48;
  localparam int unsigned PW  = 64;
  localparam logic [7:0]  SRC = 8'h0A;
  localparam logic [15:0] DST = 16'h07_05;

  logic              aclk = 1'b0;
  logic              arst;
  logic [NIN*DW-1:0] s_tdata;
  logic [NIN-1:0]    s_tvalid;
  logic [NIN-1:0]    s_tlast;
  logic [NIN-1:0]    s_tready;
  logic [PW-1:0]     tdata;
  logic              tvalid;
  logic              tready;
  logic [7:0]        src;
  logic [7:0]        dst;

  int n_chk = 0;
  int n_err = 0;

  lii_tx_mux #(.NIN(NIN), .DW(DW), .PW(PW), .SRC_ID(SRC), .DST_IDS(DST)) dut (
    .aclk              (aclk),
    .arst              (arst),
    .s_tdata           (s_tdata),
    .s_tvalid          (s_tvalid),
    .s_tlast           (s_tlast),
    .s_tready          (s_tready),
    .lii_out_p0_tdata  (tdata),
    .lii_out_p0_tvalid (tvalid),
    .lii_out_p0_tready (tready),
    .lii_out_p0_src    (src),
    .lii_out_p0_dst    (dst)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] d, input logic [7:0] de);
    chk({tag, ".vld"}, 64'(tvalid), 64'd1);
    chk({tag, ".data"}, tdata, d);
    chk({tag, ".dst"}, 64'(dst), 64'(de));
    chk({tag, ".src"}, 64'(src), 64'(SRC));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".vld"}, 64'(tvalid), 64'd0);
    chk({tag, ".data"}, tdata, 64'd0);
    chk({tag, ".dst"}, 64'(dst), 64'd0);
    chk({tag, ".src"}, 64'(src), 64'd0);
  endtask

  task automatic do_reset;
    arst = 1'b1;
    tick();
    arst = 1'b0;
  endtask

  logic [47:0] sd [3];
  logic [63:0] rr_d [4];
  logic [7:0]  rr_dst [4];
  logic [1:0]  rr_rdy [4];

  initial begin
    sd[0] = 48'h1;
    sd[1] = 48'h2;
    sd[2] = 48'hFFFF_FFFF_FFFF;
    rr_d[0] = 64'h100; rr_dst[0] = 8'h05; rr_rdy[0] = 2'b01;
    rr_d[1] = 64'h201; rr_dst[1] = 8'h07; rr_rdy[1] = 2'b10;
    rr_d[2] = 64'h102; rr_dst[2] = 8'h05; rr_rdy[2] = 2'b01;
    rr_d[3] = 64'h203; rr_dst[3] = 8'h07; rr_rdy[3] = 2'b10;

    arst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; tready = 1'b0;
    tick();
    tick();
    chk_idle("rst");
    arst = 1'b0;
    #1;
    chk("rst.rdy_none", 64'(s_tready), 64'd0);
    s_tvalid = 2'b11;
    #1;
    chk("rst.rdy_both", 64'(s_tready), 64'd1);
    s_tvalid = 2'b00;
    tick();

    // Single stream, 1-cycle latency, zero-extended upper bits
    tready = 1'b1; s_tlast = 2'b01; s_tvalid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      s_tdata[DW-1:0] = sd[i];
      #1;
      chk("single.rdy", 64'(s_tready), 64'd1);
      tick();
      chk_beat("single", 64'(sd[i]), 8'h05);
    end
    s_tvalid = 2'b00;
    tick();
    chk_idle("single.drain");

    // Round-robin from reset: s0 first, then alternate
    do_reset();
    s_tvalid = 2'b11; s_tlast = 2'b11;
    for (int k = 0; k < 4; k++) begin
      s_tdata = {48'(48'h200 + k), 48'(48'h100 + k)};
      #1;
      chk("rr.rdy", 64'(s_tready), 64'(rr_rdy[k]));
      tick();
      chk_beat("rr", rr_d[k], rr_dst[k]);
    end
    s_tvalid = 2'b00;
    tick();

    // Backpressure: two accepts then stall; pop frees space one cycle later
    tready = 1'b0; s_tvalid = 2'b01; s_tlast = 2'b01;
    for (int c = 0; c < 5; c++) begin
      s_tdata[DW-1:0] = 48'(48'h300 + c);
      #1;
      chk("bp.rdy", 64'(s_tready), (c < 2) ? 64'd1 : 64'd0);
      if (c >= 1) chk_beat("bp.hold", 64'h300, 8'h05);
      tick();
    end
    s_tdata[DW-1:0] = 48'h305; tready = 1'b1;
    #1;
    chk("bp.rdy_pop", 64'(s_tready), 64'd0);
    chk_beat("bp.out0", 64'h300, 8'h05);
    tick();
    s_tdata[DW-1:0] = 48'h306;
    #1;
    chk("bp.rdy_resume", 64'(s_tready), 64'd1);
    chk_beat("bp.out1", 64'h301, 8'h05);
    tick();
    s_tvalid = 2'b00;
    chk_beat("bp.out2", 64'h306, 8'h05);
    tick();
    chk_idle("bp.drain");

`ifdef LII_TX_PKT_LOCK_EN
    // Packet lock: 3-beat s0 packet completes before s1
    do_reset();
    s_tvalid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      s_tdata = {48'h500, 48'(48'h400 + k)};
      s_tlast = {1'b1, (k == 2) ? 1'b1 : 1'b0};
      #1;
      chk("lock.rdy", 64'(s_tready), (k < 3) ? 64'd1 : 64'd2);
      tick();
      if (k < 3) chk_beat("lock.s0", 64'(48'h400 + k), 8'h05);
      else       chk_beat("lock.s1", 64'h500, 8'h07);
    end
    s_tvalid = 2'b00;
    tick();
`endif

    // Reset mid-packet discards FIFO and lock
    do_reset();
    s_tvalid = 2'b11; s_tlast = 2'b00;
    for (int k = 0; k < 2; k++) begin
      s_tdata = {48'h700, 48'(48'h600 + k)};
      tick();
    end
    arst = 1'b1;
    tick();
    chk_idle("mrst");
    arst = 1'b0;
    #1;
    chk("mrst.rdy_s0", 64'(s_tready), 64'd1);
    s_tvalid = 2'b10;
    #1;
    chk("mrst.rdy_s1", 64'(s_tready), 64'd2);
    tick();
    chk_beat("mrst.s1", 64'h700, 8'h07);
    s_tvalid = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
